// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: MSB-first serial word transmitter with valid/ready load and done pulse.
// Define SERIAL_PATTERN_TX_PREAMBLE_EN to prefix every word with PRE_PATTERN.
module serial_pattern_tx #(
  parameter int WIDTH = 32,
  parameter logic IDLE_LEVEL = 1'b0
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
  , parameter int PRE_LEN = 8,
  parameter logic [PRE_LEN-1:0] PRE_PATTERN = 8'b1011_0110
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             x,
  output logic             x_valid,
  output logic             x_sof,
  output logic             busy,
  output logic             done
);
  localparam logic [1:0] IDLE = 2'd0, PRE = 2'd1, SHIFT = 2'd2;
  localparam int CW = $clog2(WIDTH);
  logic [1:0] state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0] cnt;
  logic last, accept;
  // cnt holds the number of data bits still to follow the one on x
  assign last = state == SHIFT && cnt == '0;
  assign load_ready = state == IDLE || last;
  assign accept = load_valid && load_ready;
  assign busy = state != IDLE;
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
  localparam int PW = $clog2(PRE_LEN + 1);
  logic [PRE_LEN-1:0] psr;
  logic [PW-1:0] pcnt;
  always_ff @(posedge clk)
    if (reset) begin
      psr <= '0;
      pcnt <= '0;
    end else if (accept) begin
      psr <= PRE_PATTERN << 1;
      pcnt <= PW'(PRE_LEN - 1);
    end else if (state == PRE) begin
      psr <= psr << 1;
      pcnt <= pcnt - 1'b1;
    end
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      x <= IDLE_LEVEL;
      x_valid <= 1'b0;
      x_sof <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
    end else begin
      done <= last;
      x_sof <= accept;
      if (accept) begin
        x_valid <= 1'b1;
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
        state <= PRE;
        x <= PRE_PATTERN[PRE_LEN-1];
        sr <= load_data;
`else
        state <= SHIFT;
        x <= load_data[WIDTH-1];
        sr <= load_data << 1;
        cnt <= CW'(WIDTH - 1);
`endif
      end else if (last) begin
        state <= IDLE;
        x <= IDLE_LEVEL;
        x_valid <= 1'b0;
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
      end else if (state == PRE) begin
        if (pcnt == '0) begin
          state <= SHIFT;
          x <= sr[WIDTH-1];
          sr <= sr << 1;
          cnt <= CW'(WIDTH - 1);
        end else
          x <= psr[PRE_LEN-1];
`endif
      end else if (state == SHIFT) begin
        x <= sr[WIDTH-1];
        sr <= sr << 1;
        cnt <= cnt - 1'b1;
      end
    end
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: directed checks of serial_pattern_tx with WIDTH=8.
module tb_serial_pattern_tx;
  logic clk = 1'b0, reset = 1'b1, load_valid = 1'b0;
  logic [7:0] load_data = '0;
  logic load_ready, x, x_valid, x_sof, busy, done;
  logic [5:0] o, e;
  int checks = 0, failures = 0;
  serial_pattern_tx #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .x(x), .x_valid(x_valid), .x_sof(x_sof), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  // {x, x_valid, x_sof, busy, load_ready, done}
  assign o = {x, x_valid, x_sof, busy, load_ready, done};
  localparam logic [5:0] IDLE_O = 6'b000010, DONE_O = 6'b000011;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    load_valid = 1'b0;
    repeat (2) begin
      tick;
      checks++;
      if (o !== IDLE_O) begin failures++; $display("FAIL reset_hold got=%b want=%b", o, IDLE_O); end
    end
    reset = 1'b0;
    repeat (3) begin
      tick;
      checks++;
      if (o !== IDLE_O) begin failures++; $display("FAIL reset_idle got=%b want=%b", o, IDLE_O); end
    end
  endtask
`ifndef SERIAL_PATTERN_TX_PREAMBLE_EN
  task automatic test_single;
    logic [7:0] w = 8'hB4;
    load_data = w;
    load_valid = 1'b1;
    tick;
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e = {w[7-i], 1'b1, i == 0, 1'b1, i == 7, 1'b0};
      checks++;
      if (o !== e) begin failures++; $display("FAIL single bit%0d got=%b want=%b", i, o, e); end
      tick;
    end
    checks++;
    if (o !== DONE_O) begin failures++; $display("FAIL single_done got=%b want=%b", o, DONE_O); end
    tick;
    checks++;
    if (o !== IDLE_O) begin failures++; $display("FAIL single_after got=%b want=%b", o, IDLE_O); end
  endtask
  task automatic test_back_to_back;
    logic [15:0] s = 16'hFF01;
    load_data = 8'hFF;
    load_valid = 1'b1;
    tick;
    load_data = 8'h01;
    for (int i = 0; i < 16; i++) begin
      e = {s[15-i], 1'b1, i == 0 || i == 8, 1'b1, i == 7 || i == 15, i == 8};
      checks++;
      if (o !== e) begin failures++; $display("FAIL b2b bit%0d got=%b want=%b", i, o, e); end
      tick;
      if (i == 7) load_valid = 1'b0;
    end
    checks++;
    if (o !== DONE_O) begin failures++; $display("FAIL b2b_done got=%b want=%b", o, DONE_O); end
    tick;
  endtask
  task automatic test_ignore;
    logic [7:0] w = 8'hAA;
    load_data = w;
    load_valid = 1'b1;
    tick;
    load_data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      load_valid = i < 7;
      e = {w[7-i], 1'b1, i == 0, 1'b1, i == 7, 1'b0};
      checks++;
      if (o !== e) begin failures++; $display("FAIL ignore bit%0d got=%b want=%b", i, o, e); end
      tick;
    end
    checks++;
    if (o !== DONE_O) begin failures++; $display("FAIL ignore_done got=%b want=%b", o, DONE_O); end
    tick;
    checks++;
    if (o !== IDLE_O) begin failures++; $display("FAIL ignore_idle got=%b want=%b", o, IDLE_O); end
  endtask
  task automatic test_reset_mid;
    logic [7:0] w = 8'hC3;
    load_data = w;
    load_valid = 1'b1;
    tick;
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = {w[7-i], 1'b1, i == 0, 1'b1, 1'b0, 1'b0};
      checks++;
      if (o !== e) begin failures++; $display("FAIL abort bit%0d got=%b want=%b", i, o, e); end
      if (i < 3) tick;
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++;
    if (o !== IDLE_O) begin failures++; $display("FAIL abort_reset got=%b want=%b", o, IDLE_O); end
    repeat (3) begin
      tick;
      checks++;
      if (o !== IDLE_O) begin failures++; $display("FAIL abort_no_done got=%b want=%b", o, IDLE_O); end
    end
    w = 8'h5A;
    load_data = w;
    load_valid = 1'b1;
    tick;
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e = {w[7-i], 1'b1, i == 0, 1'b1, i == 7, 1'b0};
      checks++;
      if (o !== e) begin failures++; $display("FAIL after_abort bit%0d got=%b want=%b", i, o, e); end
      tick;
    end
    checks++;
    if (o !== DONE_O) begin failures++; $display("FAIL after_abort_done got=%b want=%b", o, DONE_O); end
    tick;
  endtask
`else
  task automatic test_preamble;
    logic [15:0] s = {8'b1011_0110, 8'h0F};
    load_data = 8'h0F;
    load_valid = 1'b1;
    tick;
    load_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      e = {s[15-i], 1'b1, i == 0, 1'b1, i == 15, 1'b0};
      checks++;
      if (o !== e) begin failures++; $display("FAIL preamble bit%0d got=%b want=%b", i, o, e); end
      tick;
    end
    checks++;
    if (o !== DONE_O) begin failures++; $display("FAIL preamble_done got=%b want=%b", o, DONE_O); end
    tick;
    checks++;
    if (o !== IDLE_O) begin failures++; $display("FAIL preamble_idle got=%b want=%b", o, IDLE_O); end
  endtask
`endif
  initial begin
    test_reset;
`ifndef SERIAL_PATTERN_TX_PREAMBLE_EN
    test_single;
    test_back_to_back;
    test_ignore;
    test_reset_mid;
`else
    test_preamble;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
